// File: rtl/bp_me_pkg.sv
// Shared coherence-link header definitions: cord/len field widths and the header struct.
package bp_me_pkg;

  localparam int bp_cord_width_gp = 8;
  localparam int bp_len_width_gp  = 4;
  localparam int bp_hdr_width_gp  = bp_cord_width_gp + bp_len_width_gp;

  typedef struct packed {
    logic [bp_len_width_gp-1:0]  len;
    logic [bp_cord_width_gp-1:0] cord;
  } bp_hdr_s;

endpackage

// File: rtl/bp_cacc_wormhole_lock.sv
// Wormhole packet lock: latches the granted index on a header carrying body flits and
// releases it on the accept of the last body flit.
module bp_cacc_wormhole_lock
  import bp_me_pkg::*;
#(
  parameter int len_width_p = bp_len_width_gp,
  parameter int idx_width_p = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hdr_accept,
  input  logic                   flit_accept,
  input  logic [len_width_p-1:0] len,
  input  logic [idx_width_p-1:0] idx,
  output logic                   locked,
  output logic [idx_width_p-1:0] lock_idx
);

  logic [len_width_p-1:0] cnt_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked   <= 1'b0;
      cnt_p0   <= '0;
      lock_idx <= '0;
    end else if (locked) begin
      if (flit_accept) begin
        cnt_p0 <= cnt_p0 - 1'b1;
        if (cnt_p0 == len_width_p'(1)) locked <= 1'b0;
      end
    end else if (hdr_accept && (len != '0)) begin
      locked   <= 1'b1;
      cnt_p0   <= len;
      lock_idx <= idx;
    end
  end

endmodule

// File: rtl/bp_cacc_link_concentrator.sv
// Concentrates per-row coherence links onto one edge link (round-robin, wormhole locked)
// and distributes edge packets back by y-cord. Optional counters: BP_CACC_CONC_PERF_EN.
module bp_cacc_link_concentrator
  import bp_me_pkg::*;
#(
  parameter int flit_width_p   = 64,
  parameter int num_in_p       = 4,
  parameter int cord_width_p   = bp_cord_width_gp,
  parameter int x_cord_width_p = 4,
  parameter int len_width_p    = bp_len_width_gp,
  parameter int fifo_els_p     = 2
) (
  input  logic                                   coh_clk_i,
  input  logic                                   async_reset_i,
  input  logic [cord_width_p-x_cord_width_p-1:0] base_y_i,
  input  logic [num_in_p-1:0]                    row_v_i,
  input  logic [num_in_p*flit_width_p-1:0]       row_data_i,
  output logic [num_in_p-1:0]                    row_ready_and_o,
  output logic                                   edge_v_o,
  output logic [flit_width_p-1:0]                edge_data_o,
  input  logic                                   edge_ready_and_i,
  input  logic                                   edge_v_i,
  input  logic [flit_width_p-1:0]                edge_data_i,
  output logic                                   edge_ready_and_o,
  output logic [num_in_p-1:0]                    row_v_o,
  output logic [flit_width_p-1:0]                row_data_o,
  input  logic [num_in_p-1:0]                    row_ready_and_i,
  output logic                                   err_o,
  output logic [num_in_p*32-1:0]                 perf_flits_o
);

  localparam int y_width_lp   = cord_width_p - x_cord_width_p;
  localparam int idx_width_lp = $clog2(num_in_p);
  localparam int ptr_width_lp = $clog2(fifo_els_p);
  localparam int cnt_width_lp = $clog2(fifo_els_p + 1);

  logic [num_in_p-1:0]                   push, pop, empty, full;
  logic [num_in_p-1:0][flit_width_p-1:0] head;

  // Stage p0: per-row input FIFOs; head is read combinationally for 1-cycle latency
  for (genvar i = 0; i < num_in_p; i++) begin : g_fifo
    logic [flit_width_p-1:0] mem_p0 [fifo_els_p];
    logic [ptr_width_lp-1:0] wr_ptr_p0, rd_ptr_p0;
    logic [cnt_width_lp-1:0] cnt_p0;

    assign empty[i] = (cnt_p0 == '0);
    assign full[i]  = (cnt_p0 == cnt_width_lp'(fifo_els_p));
    assign push[i]  = row_v_i[i] & ~full[i];
    assign head[i]  = mem_p0[rd_ptr_p0];

    always_ff @(posedge coh_clk_i) begin
      if (push[i]) mem_p0[wr_ptr_p0] <= row_data_i[i*flit_width_p +: flit_width_p];
    end

    always_ff @(posedge coh_clk_i or posedge async_reset_i) begin
      if (async_reset_i) begin
        wr_ptr_p0 <= '0;
        rd_ptr_p0 <= '0;
        cnt_p0    <= '0;
      end else begin
        if (push[i])
          wr_ptr_p0 <= (wr_ptr_p0 == ptr_width_lp'(fifo_els_p-1)) ? '0 : wr_ptr_p0 + 1'b1;
        if (pop[i])
          rd_ptr_p0 <= (rd_ptr_p0 == ptr_width_lp'(fifo_els_p-1)) ? '0 : rd_ptr_p0 + 1'b1;
        cnt_p0 <= cnt_p0 + cnt_width_lp'(push[i]) - cnt_width_lp'(pop[i]);
      end
    end
  end

  assign row_ready_and_o = ~full;

  logic [idx_width_lp-1:0] rr_ptr_p0, hold_idx_p0, rr_idx, gnt, c_lock_idx;
  logic                    hold_v_p0, rr_v, gnt_v, c_locked, edge_accept, c_hdr_accept;

  always_comb begin
    int j;
    rr_v   = 1'b0;
    rr_idx = rr_ptr_p0;
    j      = 0;
    // Walk from lowest to highest priority so the last hit wins
    for (int k = num_in_p - 1; k >= 0; k--) begin
      j = int'(rr_ptr_p0) + k;
      if (j >= num_in_p) j = j - num_in_p;
      if (!empty[j]) begin
        rr_v   = 1'b1;
        rr_idx = idx_width_lp'(j);
      end
    end
  end

  always_comb begin
    gnt   = rr_idx;
    gnt_v = rr_v;
    if (c_locked) begin
      gnt   = c_lock_idx;
      gnt_v = ~empty[c_lock_idx];
    end else if (hold_v_p0) begin
      gnt   = hold_idx_p0;
      gnt_v = 1'b1;
    end
  end

  assign edge_v_o     = gnt_v;
  assign edge_data_o  = head[gnt];
  assign edge_accept  = gnt_v & edge_ready_and_i;
  assign c_hdr_accept = edge_accept & ~c_locked;

  always_comb begin
    pop = '0;
    pop[gnt] = edge_accept;
  end

  // Stage p1: round-robin pointer and stalled-grant hold
  always_ff @(posedge coh_clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      rr_ptr_p0   <= '0;
      hold_v_p0   <= 1'b0;
      hold_idx_p0 <= '0;
    end else begin
      if (c_hdr_accept)
        rr_ptr_p0 <= (gnt == idx_width_lp'(num_in_p-1)) ? '0 : gnt + 1'b1;
      if (gnt_v && !edge_ready_and_i && !c_locked) begin
        hold_v_p0   <= 1'b1;
        hold_idx_p0 <= gnt;
      end else if (edge_accept) begin
        hold_v_p0 <= 1'b0;
      end
    end
  end

  bp_cacc_wormhole_lock #(.len_width_p(len_width_p), .idx_width_p(idx_width_lp)) u_conc_lock (
    .clk         (coh_clk_i),
    .rst         (async_reset_i),
    .hdr_accept  (c_hdr_accept),
    .flit_accept (edge_accept),
    .len         (head[gnt][cord_width_p+len_width_p-1:cord_width_p]),
    .idx         (gnt),
    .locked      (c_locked),
    .lock_idx    (c_lock_idx)
  );

  logic [y_width_lp-1:0] d_hdr_idx, d_lock_idx, d_cur_idx;
  logic                  d_locked, d_in_range, d_accept, d_hdr_accept;

  // Subtraction wraps modulo the y width, so rows below base_y land out of range
  assign d_hdr_idx  = edge_data_i[cord_width_p-1:x_cord_width_p] - base_y_i;
  assign d_cur_idx  = d_locked ? d_lock_idx : d_hdr_idx;
  assign d_in_range = (32'(d_cur_idx) < 32'(num_in_p));
  assign row_data_o = edge_data_i;

  always_comb begin
    row_v_o          = '0;
    edge_ready_and_o = 1'b1;
    if (!async_reset_i && d_in_range) begin
      row_v_o[d_cur_idx[idx_width_lp-1:0]] = edge_v_i;
      edge_ready_and_o = row_ready_and_i[d_cur_idx[idx_width_lp-1:0]];
    end
  end

  assign d_accept     = edge_v_i & edge_ready_and_o;
  assign d_hdr_accept = d_accept & ~d_locked;

  bp_cacc_wormhole_lock #(.len_width_p(len_width_p), .idx_width_p(y_width_lp)) u_dist_lock (
    .clk         (coh_clk_i),
    .rst         (async_reset_i),
    .hdr_accept  (d_hdr_accept),
    .flit_accept (d_accept),
    .len         (edge_data_i[cord_width_p+len_width_p-1:cord_width_p]),
    .idx         (d_hdr_idx),
    .locked      (d_locked),
    .lock_idx    (d_lock_idx)
  );

  always_ff @(posedge coh_clk_i or posedge async_reset_i) begin
    if (async_reset_i)                  err_o <= 1'b0;
    else if (d_hdr_accept && !d_in_range) err_o <= 1'b1;
  end

`ifdef BP_CACC_CONC_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  for (genvar i = 0; i < num_in_p; i++) begin : g_perf
    logic [31:0] perf_p0;
    always_ff @(posedge coh_clk_i or posedge async_reset_i) begin
      if (async_reset_i) perf_p0 <= '0;
      else if (push[i])  perf_p0 <= sat_inc(perf_p0);
    end
    assign perf_flits_o[i*32 +: 32] = perf_p0;
  end
`else
  assign perf_flits_o = '0;
`endif

endmodule

// File: tb/tb_bp_cacc_link_concentrator.sv
// Directed bench for bp_cacc_link_concentrator: concentrate ordering, locking, grant hold,
// distribute routing and out-of-range drop.
module tb_bp_cacc_link_concentrator;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   base_y;
  logic [3:0]   row_v_i;
  logic [255:0] row_data_i;
  logic [3:0]   row_ready_and_o;
  logic         edge_v_o;
  logic [63:0]  edge_data_o;
  logic         edge_ready_and_i;
  logic         edge_v_i;
  logic [63:0]  edge_data_i;
  logic         edge_ready_and_o;
  logic [3:0]   row_v_o;
  logic [63:0]  row_data_o;
  logic [3:0]   row_ready_and_i;
  logic         err_o;
  logic [127:0] perf_flits_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bp_cacc_link_concentrator dut (
    .coh_clk_i        (clk),
    .async_reset_i    (rst),
    .base_y_i         (base_y),
    .row_v_i          (row_v_i),
    .row_data_i       (row_data_i),
    .row_ready_and_o  (row_ready_and_o),
    .edge_v_o         (edge_v_o),
    .edge_data_o      (edge_data_o),
    .edge_ready_and_i (edge_ready_and_i),
    .edge_v_i         (edge_v_i),
    .edge_data_i      (edge_data_i),
    .edge_ready_and_o (edge_ready_and_o),
    .row_v_o          (row_v_o),
    .row_data_o       (row_data_o),
    .row_ready_and_i  (row_ready_and_i),
    .err_o            (err_o),
    .perf_flits_o     (perf_flits_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input int tag, input int len, input logic [7:0] cord);
    logic [51:0] t;
    logic [3:0]  l;
    t = 52'(tag);
    l = 4'(len);
    return {t, l, cord};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int row, input logic [63:0] d);
    row_v_i[row] = 1'b1;
    row_data_i[row*64 +: 64] = d;
  endtask

  logic [63:0] A, B, C, D, H1, B1, B2, B3, H3, E0, F3, G0, G1, P, Q, R, S, S2, V;

  initial begin
    A  = hdr(1, 0, 8'h00);  B  = hdr(2, 0, 8'h00);
    C  = hdr(3, 0, 8'h00);  D  = hdr(4, 0, 8'h00);
    H1 = hdr(5, 3, 8'h00);  B1 = hdr(6, 7, 8'h00);
    B2 = hdr(8, 5, 8'h00);  B3 = hdr(9, 1, 8'h00);
    H3 = hdr(7, 0, 8'h00);  E0 = hdr(10, 0, 8'h00);
    F3 = hdr(11, 0, 8'h00); G1 = hdr(12, 0, 8'h00);
    G0 = hdr(13, 0, 8'h00); P  = hdr(20, 1, 8'h40);
    Q  = hdr(21, 0, 8'h00); R  = hdr(22, 2, 8'h90);
    S  = hdr(23, 0, 8'h30); S2 = hdr(24, 0, 8'h20);
    V  = hdr(25, 0, 8'h50);

    rst = 1'b1; base_y = 4'd2; row_v_i = '0; row_data_i = '0;
    edge_ready_and_i = 1'b1; edge_v_i = 1'b0; edge_data_i = '0; row_ready_and_i = 4'hF;
    #12;
    check("rst_edge_v", 64'(edge_v_o), 64'd0);
    check("rst_row_v", 64'(row_v_o), 64'd0);
    check("rst_row_rdy", 64'(row_ready_and_o), 64'hF);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_edge_rdy", 64'(edge_ready_and_o), 64'd1);
    tick;
    rst = 1'b0;

    // Rows 0 and 2 together, pointer at 0
    put(0, A); put(2, B);
    tick; row_v_i = '0;
    check("rr_first_v", 64'(edge_v_o), 64'd1);
    check("rr_first", edge_data_o, A);
    tick; check("rr_second", edge_data_o, B);
    tick; check("rr_idle", 64'(edge_v_o), 64'd0);

    // Pointer now 3: row 3 beats row 0
    put(0, C); put(3, D);
    tick; row_v_i = '0; check("ptr3_first", edge_data_o, D);
    tick; check("ptr3_second", edge_data_o, C);
    tick; check("ptr3_idle", 64'(edge_v_o), 64'd0);

    // Row 1 locked packet with a 2-cycle stall, row 3 waits
    put(1, H1);
    tick; row_v_i = '0; check("lock_hdr", edge_data_o, H1);
    put(1, B1); put(3, H3);
    tick; row_v_i = '0; check("lock_b1", edge_data_o, B1);
    tick; check("lock_stall1", 64'(edge_v_o), 64'd0);
    tick; check("lock_stall2", 64'(edge_v_o), 64'd0);
    put(1, B2);
    tick; row_v_i = '0; check("lock_b2", edge_data_o, B2);
    put(1, B3);
    tick; row_v_i = '0; check("lock_b3", edge_data_o, B3);
    tick; check("lock_after", edge_data_o, H3);
    tick; check("lock_idle", 64'(edge_v_o), 64'd0);

    // Edge stalled 5 cycles with row 0 granted, row 3 arriving
    edge_ready_and_i = 1'b0;
    put(0, E0);
    tick; row_v_i = '0; check("stall_c1", edge_data_o, E0);
    put(3, F3);
    tick; row_v_i = '0; check("stall_c2", edge_data_o, E0);
    for (int c = 3; c <= 5; c++) begin
      tick;
      check("stall_v", 64'(edge_v_o), 64'd1);
      check("stall_data", edge_data_o, E0);
    end
    edge_ready_and_i = 1'b1; #1;
    check("stall_release", edge_data_o, E0);
    tick; check("stall_next", edge_data_o, F3);
    tick; check("stall_idle", 64'(edge_v_o), 64'd0);

    // Hold against a higher-priority newcomer (pointer 0, row 1 held, row 0 arrives)
    edge_ready_and_i = 1'b0;
    put(1, G1);
    tick; row_v_i = '0; check("hold_c1", edge_data_o, G1);
    put(0, G0);
    tick; row_v_i = '0; check("hold_c2", edge_data_o, G1);
    tick; check("hold_c3", edge_data_o, G1);
    edge_ready_and_i = 1'b1;
    tick; check("hold_next", edge_data_o, G0);
    tick; check("hold_idle", 64'(edge_v_o), 64'd0);

    // Distribute: y=4, base 2 -> row 2, row 2 not ready for 2 cycles
    row_ready_and_i = 4'b1011;
    edge_v_i = 1'b1; edge_data_i = P; #1;
    check("dist_v_c1", 64'(row_v_o), 64'h4);
    check("dist_rdy_c1", 64'(edge_ready_and_o), 64'd0);
    check("dist_data", row_data_o, P);
    tick; #1;
    check("dist_v_c2", 64'(row_v_o), 64'h4);
    check("dist_rdy_c2", 64'(edge_ready_and_o), 64'd0);
    row_ready_and_i = 4'hF; #1;
    check("dist_rdy_c3", 64'(edge_ready_and_o), 64'd1);
    tick;
    edge_data_i = Q; #1;
    check("dist_body_v", 64'(row_v_o), 64'h4);
    check("dist_body_rdy", 64'(edge_ready_and_o), 64'd1);
    tick;
    edge_v_i = 1'b0; #1;
    check("dist_done_v", 64'(row_v_o), 64'd0);
    check("dist_err", 64'(err_o), 64'd0);

    // Out-of-range y=9 (idx 7), len 2: drop 3 flits, sticky error
    row_ready_and_i = 4'h0;
    edge_v_i = 1'b1; edge_data_i = R; #1;
    check("drop_hdr_rdy", 64'(edge_ready_and_o), 64'd1);
    check("drop_hdr_v", 64'(row_v_o), 64'd0);
    tick;
    edge_data_i = S; #1;
    check("drop_err", 64'(err_o), 64'd1);
    check("drop_b1_rdy", 64'(edge_ready_and_o), 64'd1);
    check("drop_b1_v", 64'(row_v_o), 64'd0);
    tick;
    edge_data_i = S2; #1;
    check("drop_b2_rdy", 64'(edge_ready_and_o), 64'd1);
    check("drop_b2_v", 64'(row_v_o), 64'd0);
    tick;
    row_ready_and_i = 4'hF; edge_data_i = V; #1;
    check("post_drop_v", 64'(row_v_o), 64'h8);
    check("post_drop_rdy", 64'(edge_ready_and_o), 64'd1);
    tick;
    edge_v_i = 1'b0; #1;
    check("err_sticky", 64'(err_o), 64'd1);
    check("post_idle_v", 64'(row_v_o), 64'd0);

`ifdef BP_CACC_CONC_PERF_EN
    check("perf_row0", 64'(perf_flits_o[31:0]), 64'd4);
    check("perf_row1", 64'(perf_flits_o[63:32]), 64'd5);
    check("perf_row2", 64'(perf_flits_o[95:64]), 64'd1);
    check("perf_row3", 64'(perf_flits_o[127:96]), 64'd3);
`else
    check("perf_lo", perf_flits_o[63:0], 64'd0);
    check("perf_hi", perf_flits_o[127:64], 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
